// File: rtl/df_response_checker.sv
// Self-test engine: sweeps x/y through all four vectors, samples q1/q2/q3 after
// a settle interval and compares against an expected truth table.
module df_response_checker #(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter logic [11:0] EXP_TABLE     = 12'hCD8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       q1,
  input  logic       q2,
  input  logic       q3,
  output logic       x,
  output logic       y,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_cnt,
  output logic [3:0] fail_vec
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t     state;
  logic [1:0] idx;
  logic [7:0] cnt;
  logic [2:0] expected;
  logic       mism;
  logic       last_cycle;

  always_comb begin
    expected = '0;
    case (idx)
      2'd0: expected = EXP_TABLE[2:0];
      2'd1: expected = EXP_TABLE[5:3];
      2'd2: expected = EXP_TABLE[8:6];
      2'd3: expected = EXP_TABLE[11:9];
      default: expected = '0;
    endcase
  end

  assign mism       = ({q1, q2, q3} != expected);
  assign last_cycle = (cnt == 8'(SETTLE_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      idx      <= '0;
      cnt      <= '0;
      x        <= 1'b0;
      y        <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
      err_cnt  <= '0;
      fail_vec <= '0;
    end else begin
      case (state)
        IDLE: begin
          x    <= 1'b0;
          y    <= 1'b0;
          done <= 1'b0;
          busy <= 1'b0;
          if (start) begin
            state    <= RUN;
            idx      <= '0;
            cnt      <= '0;
            err_cnt  <= '0;
            fail_vec <= '0;
            pass     <= 1'b0;
            busy     <= 1'b1;
          end
        end
        RUN: begin
          cnt <= cnt + 8'd1;
          if (last_cycle) begin
            cnt <= '0;
            if (mism) begin
              fail_vec[idx] <= 1'b1;
              err_cnt       <= err_cnt + 3'd1;
            end
            if (idx == 2'd3) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              x     <= 1'b0;
              y     <= 1'b0;
              // Final vector's result is folded in here, not yet visible in err_cnt
              pass  <= (err_cnt == '0) && !mism;
            end else begin
              idx      <= idx + 2'd1;
              {x, y}   <= idx + 2'd1;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_df_response_checker.sv
// Directed bench for df_response_checker with behavioural models of the block
// under test (correct, q3 stuck at 0, outputs delayed two cycles).
module tb_df_response_checker;

  logic clk = 1'b0;
  logic rst_n;
  logic start, start1;
  int   mode;  // 0 correct, 1 q3 stuck at 0, 2 delayed by 2 cycles

  logic       x4, y4, busy4, done4, pass4;
  logic [2:0] err4;
  logic [3:0] fv4;
  logic       q1_4, q2_4, q3_4;
  logic [1:0] d1_4, d2_4;

  logic       x1, y1, busy1, done1, pass1;
  logic [2:0] err1;
  logic [3:0] fv1;
  logic       q1_1, q2_1, q3_1;
  logic [1:0] d1_1, d2_1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    d1_4 <= {x4, y4};
    d2_4 <= d1_4;
    d1_1 <= {x1, y1};
    d2_1 <= d1_1;
  end

  always_comb begin
    if (mode == 2) begin
      q1_4 = d2_4[1] & d2_4[0]; q2_4 = d2_4[1] | d2_4[0]; q3_4 = d2_4[1] ^ d2_4[0];
      q1_1 = d2_1[1] & d2_1[0]; q2_1 = d2_1[1] | d2_1[0]; q3_1 = d2_1[1] ^ d2_1[0];
    end else begin
      q1_4 = x4 & y4; q2_4 = x4 | y4; q3_4 = (mode == 1) ? 1'b0 : (x4 ^ y4);
      q1_1 = x1 & y1; q2_1 = x1 | y1; q3_1 = (mode == 1) ? 1'b0 : (x1 ^ y1);
    end
  end

  df_response_checker #(.SETTLE_CYCLES(4), .EXP_TABLE(12'hCD8)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start),
    .q1(q1_4), .q2(q2_4), .q3(q3_4),
    .x(x4), .y(y4), .busy(busy4), .done(done4), .pass(pass4),
    .err_cnt(err4), .fail_vec(fv4)
  );

  df_response_checker #(.SETTLE_CYCLES(1), .EXP_TABLE(12'hCD8)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1),
    .q1(q1_1), .q2(q2_1), .q3(q3_1),
    .x(x1), .y(y1), .busy(busy1), .done(done1), .pass(pass1),
    .err_cnt(err1), .fail_vec(fv1)
  );

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Outputs packed as {busy,done,pass,err_cnt,fail_vec} minus x/y for compact compares
  task automatic check_all4(input string tag, input logic b, input logic d, input logic p,
                            input logic [2:0] e, input logic [3:0] f);
    check({tag, "_busy"}, {7'd0, busy4}, {7'd0, b});
    check({tag, "_done"}, {7'd0, done4}, {7'd0, d});
    check({tag, "_pass"}, {7'd0, pass4}, {7'd0, p});
    check({tag, "_err"},  {5'd0, err4},  {5'd0, e});
    check({tag, "_fvec"}, {4'd0, fv4},   {4'd0, f});
  endtask

  int ndone;
  int done_at;
  int done_at2;

  initial begin
    rst_n  = 1'b0;
    start  = 1'b0;
    start1 = 1'b0;
    mode   = 0;
    #2;
    check_all4("reset", 1'b0, 1'b0, 1'b0, 3'd0, 4'd0);
    check("reset_xy", {6'd0, x4, y4}, 8'd0);
    tick(2);
    rst_n = 1'b1;
    tick(2);

    // Correct model: x/y steps every 4 cycles, done after E0+16
    start = 1'b1;
    tick(1);
    start = 1'b0;
    for (int k = 0; k < 16; k++) begin
      check($sformatf("t1_xy_%0d", k), {6'd0, x4, y4}, 8'(k / 4));
      check($sformatf("t1_busy_%0d", k), {7'd0, busy4}, 8'd1);
      check($sformatf("t1_done_%0d", k), {7'd0, done4}, 8'd0);
      tick(1);
    end
    check_all4("t1_end", 1'b0, 1'b1, 1'b1, 3'd0, 4'b0000);
    check("t1_end_xy", {6'd0, x4, y4}, 8'd0);
    tick(1);
    check_all4("t1_idle", 1'b0, 1'b0, 1'b1, 3'd0, 4'b0000);

    // q3 stuck at 0: vectors 01 and 10 mismatch
    mode  = 1;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(16);
    check_all4("t2_end", 1'b0, 1'b1, 1'b0, 3'd2, 4'b0110);
    ndone = 0;
    for (int k = 0; k < 20; k++) begin
      tick(1);
      if (done4) ndone++;
    end
    check_all4("t2_hold", 1'b0, 1'b0, 1'b0, 3'd2, 4'b0110);
    check("t2_nodone", 8'(ndone), 8'd0);

    // Outputs delayed by 2 cycles: tolerated at 4 settle cycles
    mode  = 2;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(16);
    check_all4("t3_s4", 1'b0, 1'b1, 1'b1, 3'd0, 4'b0000);
    tick(2);

    // Same delay with 1 settle cycle: vectors 1..3 see stale responses
    start1 = 1'b1;
    tick(1);
    start1 = 1'b0;
    tick(3);
    check("t3_s1_done_early", {7'd0, done1}, 8'd0);
    tick(1);
    check("t3_s1_done", {7'd0, done1}, 8'd1);
    check("t3_s1_pass", {7'd0, pass1}, 8'd0);
    check("t3_s1_err",  {5'd0, err1},  8'd3);
    check("t3_s1_fvec", {4'd0, fv1},   8'b1110);
    tick(2);

    // start pulsed again mid-sweep must be ignored
    mode  = 0;
    start = 1'b1;
    tick(1);
    start   = 1'b0;
    ndone   = 0;
    done_at = -1;
    for (int k = 1; k <= 30; k++) begin
      tick(1);
      if (done4) begin
        ndone++;
        done_at = k;
      end
      start = (k == 6);
    end
    check("t4_ndone", 8'(ndone), 8'd1);
    check("t4_done_at", 8'(done_at), 8'd16);
    check_all4("t4_idle", 1'b0, 1'b0, 1'b1, 3'd0, 4'b0000);

    // Asynchronous reset mid-sweep
    mode  = 1;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(9);
    check("t5_pre_busy", {7'd0, busy4}, 8'd1);
    check("t5_pre_xy", {6'd0, x4, y4}, 8'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check_all4("t5_async", 1'b0, 1'b0, 1'b0, 3'd0, 4'b0000);
    check("t5_async_xy", {6'd0, x4, y4}, 8'd0);
    tick(2);
    rst_n = 1'b1;
    check_all4("t5_released", 1'b0, 1'b0, 1'b0, 3'd0, 4'b0000);
    mode  = 0;
    tick(1);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(16);
    check_all4("t5_fresh", 1'b0, 1'b1, 1'b1, 3'd0, 4'b0000);
    tick(2);

    // start held high: back-to-back sweeps, results cleared at each start
    mode     = 1;
    start    = 1'b1;
    ndone    = 0;
    done_at  = -1;
    done_at2 = -1;
    tick(1);
    for (int k = 1; k <= 36; k++) begin
      tick(1);
      if (done4) begin
        ndone++;
        if (done_at < 0) done_at = k;
        else done_at2 = k;
      end
      if (k == 17) check("t6_err_held", {5'd0, err4}, 8'd2);
      if (k == 18) begin
        check("t6_err_clr", {5'd0, err4}, 8'd0);
        check("t6_fvec_clr", {4'd0, fv4}, 8'd0);
        check("t6_busy2", {7'd0, busy4}, 8'd1);
      end
    end
    start = 1'b0;
    check("t6_ndone", 8'(ndone), 8'd2);
    check("t6_done1", 8'(done_at), 8'd16);
    check("t6_done2", 8'(done_at2), 8'd34);
    tick(20);
    check_all4("t6_final", 1'b0, 1'b0, 1'b0, 3'd2, 4'b0110);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/df_response_checker.md
Name: df_response_checker

Overview:
- Synthesizable on-board self-test engine for the 2-input / 3-output dataflow logic block.
- Is the opposite end of that block's exhaustive x/y stimulus sweep:
  - drives the x/y inputs through all four combinations;
  - captures q1/q2/q3 for each combination and compares them against a parameterised expected truth table;
  - reports pass/fail, error count and a failing-vector bitmap.
- Sits between board switches/LEDs and the block under test.

Parameters:
- SETTLE_CYCLES, 4: clock cycles each vector is held before q is sampled; legal range 1..255.
- EXP_TABLE, 12'hCD8: expected responses.
  - Bits [3k+2:3k] = {q1,q2,q3} for vector k, where k = {x,y}.
  - Default encodes q1=x&y, q2=x|y, q3=x^y.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  level; sampled only in IDLE; begins a sweep
- q1  in  1  response bit from block under test
- q2  in  1  response bit from block under test
- q3  in  1  response bit from block under test
- x  out  1  stimulus to block under test
- y  out  1  stimulus to block under test
- busy  out  1  high while sweep in progress
- done  out  1  one-cycle pulse when sweep completes
- pass  out  1  1 when last completed sweep had zero mismatches
- err_cnt  out  3  mismatching vectors in last sweep, 0..4
- fail_vec  out  4  bit k set if vector k mismatched

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; idx=0; settle counter=0.
  - x=0, y=0, busy=0, done=0, pass=0, err_cnt=0, fail_vec=0.
  - Reset mid-sweep aborts immediately with these values; no partial result is retained.
- States: IDLE, RUN, DONE.
- IDLE:
  - x/y held 0.
  - On an edge with start=1: go to RUN; idx=0; cnt=0; err_cnt=0; fail_vec=0; pass=0.
- RUN:
  - busy=1; {x,y}=idx, registered (changes on the same edge idx changes).
  - cnt increments each cycle.
  - On the edge where cnt==SETTLE_CYCLES-1:
    - compare {q1,q2,q3} with EXP_TABLE[3*idx+2:3*idx];
    - on mismatch, set fail_vec[idx] and increment err_cnt;
    - cnt=0.
    - If idx==3, go to DONE; otherwise idx increments.
  - Each vector is therefore held exactly SETTLE_CYCLES cycles. Sampling occurs only on the last held cycle.
- DONE:
  - Lasts exactly one cycle: done=1, busy=0.
  - pass = (err_cnt==0), using the final count including the last vector.
  - Next edge returns to IDLE unconditionally.
- Latency: start accepted at edge E0 → final sample at E0+4*SETTLE_CYCLES → done high for the cycle following that edge.
- start:
  - ignored in RUN and DONE;
  - if still high in IDLE after DONE, a new sweep starts (results are cleared at that start).
- Results:
  - pass, err_cnt and fail_vec hold their values from DONE until the next accepted start or reset.
  - err_cnt cannot overflow (max 4).
- x/y return to 0 on entering DONE/IDLE.
- q inputs are treated as synchronous to clk; the block does no metastability filtering.

Test Plan:
- Correct model (q1=x&y, q2=x|y, q3=x^y), SETTLE_CYCLES=4, start pulsed at E0:
  - x/y step 00,01,10,11 every 4 cycles;
  - done pulses during cycle after E0+16;
  - pass=1, err_cnt=0, fail_vec=4'b0000.
- Model with q3 stuck at 0:
  - err_cnt=2, fail_vec=4'b0110, pass=0;
  - results remain stable for 20 further cycles with start=0.
- Model outputs delayed 2 cycles:
  - SETTLE_CYCLES=4 gives pass=1;
  - SETTLE_CYCLES=1 gives pass=0, fail_vec≠0; done at E0+4.
- start toggled high during RUN (cycle E0+6):
  - sweep unaffected; done still exactly once at E0+16; no restart.
- rst_n pulsed low at E0+9 mid-sweep:
  - all outputs 0 immediately (asynchronous, before the next clk edge);
  - after release, a fresh start gives a full correct sweep.
- start held high continuously:
  - back-to-back sweeps with period 4*SETTLE_CYCLES+2 cycles;
  - err_cnt/fail_vec cleared at each new start.
